// File: rtl/branch_seq_pkg.sv
// Shared types and constants for the fetch-side branch sequencer.
// Holds the datapath width, the state encoding and the PC arithmetic constants.
package branch_seq_pkg;

  localparam int FULLW = 32;

  typedef logic [FULLW-1:0] word_t;

  localparam word_t PC_INC = 32'd4;
  localparam word_t PC_OFS = 32'd8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } seq_state_e;

  // Branch target relative to the decoded instruction; wraps modulo 2^FULLW.
  function automatic word_t branch_target(input word_t pc, input word_t bv);
    return pc + PC_OFS + bv;
  endfunction

endpackage

// File: rtl/branch_seq_if.sv
// Decode/execute/fetch signal bundle for branch_seq.
// The master side drives decode and execute indications; the slave side is the sequencer.
interface branch_seq_if import branch_seq_pkg::*; ();

  logic  dec_valid;
  logic  dec_ib;
  logic  dec_link;
  word_t dec_pc;
  word_t dec_bv;
  logic  ex_valid;
  logic  ex_cond_pass;
  word_t pc_out;
  logic  fetch_en;
  logic  flush_fd;
  logic  lr_we;
  word_t lr_data;
  logic  busy;

  modport master (
    output dec_valid, dec_ib, dec_link, dec_pc, dec_bv, ex_valid, ex_cond_pass,
    input  pc_out, fetch_en, flush_fd, lr_we, lr_data, busy
  );

  modport slave (
    input  dec_valid, dec_ib, dec_link, dec_pc, dec_bv, ex_valid, ex_cond_pass,
    output pc_out, fetch_en, flush_fd, lr_we, lr_data, busy
  );

endinterface

// File: rtl/branch_seq.sv
// Fetch-side branch sequencer: owns the fetch PC, holds fetch while a branch
// resolves, redirects on a taken branch and issues the BL link-register write.
module branch_seq import branch_seq_pkg::*; #(
  parameter word_t RESET_PC  = {FULLW{1'b0}},
  parameter int    FLUSH_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_in,
  branch_seq_if.slave bus
);

  localparam logic [2:0] FLUSH_CNT = FLUSH_CYC[2:0];

  seq_state_e state_r, state_s;
  logic [2:0] cnt_r, cnt_s;
  word_t      pc_r, pc_s;
  word_t      tgt_r, tgt_s;
  logic       link_r, link_s;
  word_t      lr_val_r, lr_val_s;
  logic       fetch_en_r, fetch_en_s;
  logic       flush_fd_r, flush_fd_s;
  logic       lr_we_r, lr_we_s;
  word_t      lr_data_r, lr_data_s;
  logic       busy_r, busy_s;

  // Next-state, capture and registered-output values; a stall holds everything and drops pulses.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    pc_s       = pc_r;
    tgt_s      = tgt_r;
    link_s     = link_r;
    lr_val_s   = lr_val_r;
    fetch_en_s = fetch_en_r;
    busy_s     = busy_r;
    flush_fd_s = 1'b0;
    lr_we_s    = 1'b0;
    lr_data_s  = lr_data_r;
    if (!stall_in) begin
      case (state_r)
        ST_RUN: begin
          if (bus.dec_valid && bus.dec_ib) begin
            tgt_s    = branch_target(bus.dec_pc, bus.dec_bv);
            link_s   = bus.dec_link;
            lr_val_s = bus.dec_pc + PC_INC;
            state_s  = ST_RESOLVE;
          end else if (fetch_en_r) begin
            // Advance only past an address that has actually been fetched.
            pc_s = pc_r + PC_INC;
          end else begin
            pc_s = pc_r;
          end
        end
        ST_RESOLVE: begin
          if (bus.ex_valid && bus.ex_cond_pass) begin
            pc_s       = tgt_r;
            flush_fd_s = 1'b1;
            lr_we_s    = link_r;
            if (link_r) begin
              lr_data_s = lr_val_r;
            end else begin
              lr_data_s = lr_data_r;
            end
            cnt_s   = FLUSH_CNT;
            state_s = ST_FLUSH;
          end else if (bus.ex_valid) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_RESOLVE;
          end
        end
        ST_FLUSH: begin
          cnt_s = cnt_r - 3'd1;
          if (cnt_s == 3'd0) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_FLUSH;
          end
        end
        default: begin
          state_s = ST_RUN;
        end
      endcase
      fetch_en_s = (state_s == ST_RUN);
      busy_s     = (state_s != ST_RUN);
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RUN;
      cnt_r      <= 3'd0;
      pc_r       <= RESET_PC;
      tgt_r      <= {FULLW{1'b0}};
      link_r     <= 1'b0;
      lr_val_r   <= {FULLW{1'b0}};
      fetch_en_r <= 1'b0;
      flush_fd_r <= 1'b0;
      lr_we_r    <= 1'b0;
      lr_data_r  <= {FULLW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pc_r       <= pc_s;
      tgt_r      <= tgt_s;
      link_r     <= link_s;
      lr_val_r   <= lr_val_s;
      fetch_en_r <= fetch_en_s;
      flush_fd_r <= flush_fd_s;
      lr_we_r    <= lr_we_s;
      lr_data_r  <= lr_data_s;
      busy_r     <= busy_s;
    end
  end

  assign bus.pc_out   = pc_r;
  assign bus.fetch_en = fetch_en_r;
  assign bus.flush_fd = flush_fd_r;
  assign bus.lr_we    = lr_we_r;
  assign bus.lr_data  = lr_data_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed scenarios plus randomized branches
// checked against a timing-rule model of fetch PC, pulses and bubble length.
module tb_branch_seq;
  import branch_seq_pkg::*;

  localparam word_t RPC = 32'h0000_0100;
  localparam int    FC  = 3;

  logic clk = 1'b0;
  logic reset;
  logic stall_in;

  branch_seq_if bif();

  branch_seq #(.RESET_PC(RPC), .FLUSH_CYC(FC)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  word_t exp_pc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {pc_out, fetch_en, flush_fd, lr_we, busy}
  function automatic logic [35:0] obs();
    return {bif.pc_out, bif.fetch_en, bif.flush_fd, bif.lr_we, bif.busy};
  endfunction

  task automatic test_reset();
    reset = 1'b1; stall_in = 1'b0;
    bif.dec_valid = 1'b0; bif.dec_ib = 1'b0; bif.dec_link = 1'b0;
    bif.dec_pc = 32'h0; bif.dec_bv = 32'h0; bif.ex_valid = 1'b0; bif.ex_cond_pass = 1'b0;
    step(); step();
    checks++;
    if (obs() !== {RPC, 4'b0000} || bif.lr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got %h lr_data=%h, want %h lr_data=0", obs(), bif.lr_data, {RPC, 4'b0000});
    end
    reset = 1'b0;
    exp_pc = RPC;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs() !== {exp_pc, 4'b1000}) begin
        failures++;
        $display("FAIL reset_run[%0d]: got %h, want %h", i, obs(), {exp_pc, 4'b1000});
      end
      if (i < 2) exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic run_cycles(input int n, input bit allow_stall);
    for (int i = 0; i < n; i++) begin
      stall_in = allow_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
      if (!stall_in) exp_pc = exp_pc + 32'd4;
      checks++;
      if (obs() !== {exp_pc, 4'b1000}) begin
        failures++;
        $display("FAIL run: got %h, want %h (stall=%b)", obs(), {exp_pc, 4'b1000}, stall_in);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic do_branch(input word_t pc, input word_t bv, input bit link, input bit taken,
                           input int dly, input int stall_res, input int stall_fl, input string name);
    word_t tgt;
    tgt = pc + 32'd8 + bv;
    bif.dec_valid = 1'b1; bif.dec_ib = 1'b1; bif.dec_link = link;
    bif.dec_pc = pc; bif.dec_bv = bv;
    step();
    bif.dec_valid = 1'b0; bif.dec_ib = 1'b0;
    checks++;
    if (obs() !== {exp_pc, 4'b0001}) begin
      failures++;
      $display("FAIL %s_decode: got %h, want %h", name, obs(), {exp_pc, 4'b0001});
    end
    // Resolve wait; decode noise here must be ignored.
    for (int i = 0; i < dly; i++) begin
      bif.ex_valid = 1'b0; bif.ex_cond_pass = 1'($urandom);
      bif.dec_valid = 1'($urandom); bif.dec_ib = 1'($urandom); bif.dec_pc = $urandom;
      step();
      checks++;
      if (obs() !== {exp_pc, 4'b0001}) begin
        failures++;
        $display("FAIL %s_wait: got %h, want %h", name, obs(), {exp_pc, 4'b0001});
      end
    end
    bif.dec_valid = 1'b0; bif.dec_ib = 1'b0;
    bif.ex_valid = 1'b1; bif.ex_cond_pass = taken;
    stall_in = 1'b1;
    for (int i = 0; i < stall_res; i++) begin
      step();
      checks++;
      if (obs() !== {exp_pc, 4'b0001}) begin
        failures++;
        $display("FAIL %s_res_stall: got %h, want %h", name, obs(), {exp_pc, 4'b0001});
      end
    end
    stall_in = 1'b0;
    step();
    bif.ex_valid = 1'b0;
    if (taken) begin
      checks++;
      if (obs() !== {tgt, 1'b0, 1'b1, link, 1'b1}) begin
        failures++;
        $display("FAIL %s_redirect: got %h, want %h", name, obs(), {tgt, 1'b0, 1'b1, link, 1'b1});
      end
      if (link) begin
        checks++;
        if (bif.lr_data !== pc + 32'd4) begin
          failures++;
          $display("FAIL %s_lr_data: got %h, want %h", name, bif.lr_data, pc + 32'd4);
        end
      end
      for (int j = 1; j <= FC; j++) begin
        if (j == 2) begin
          stall_in = 1'b1;
          for (int s = 0; s < stall_fl; s++) begin
            step();
            checks++;
            if (obs() !== {tgt, 4'b0001}) begin
              failures++;
              $display("FAIL %s_flush_stall: got %h, want %h", name, obs(), {tgt, 4'b0001});
            end
          end
          stall_in = 1'b0;
        end
        step();
        checks++;
        if (obs() !== ((j < FC) ? {tgt, 4'b0001} : {tgt, 4'b1000})) begin
          failures++;
          $display("FAIL %s_flush[%0d]: got %h, want %h", name, j, obs(),
                   (j < FC) ? {tgt, 4'b0001} : {tgt, 4'b1000});
        end
      end
      exp_pc = tgt;
    end else begin
      checks++;
      if (obs() !== {exp_pc, 4'b1000}) begin
        failures++;
        $display("FAIL %s_not_taken: got %h, want %h", name, obs(), {exp_pc, 4'b1000});
      end
    end
    step();
    exp_pc = exp_pc + 32'd4;
    checks++;
    if (obs() !== {exp_pc, 4'b1000}) begin
      failures++;
      $display("FAIL %s_resume: got %h, want %h", name, obs(), {exp_pc, 4'b1000});
    end
  endtask

  task automatic test_taken_b();
    run_cycles(2, 1'b0);
    do_branch(32'h200, 32'h40, 1'b0, 1'b1, 1, 0, 0, "taken_b");
  endtask

  task automatic test_taken_bl();
    do_branch(32'h1000, 32'hFFFF_FFF0, 1'b1, 1'b1, 0, 0, 0, "taken_bl");
  endtask

  task automatic test_not_taken();
    do_branch(32'h300, 32'h80, 1'b1, 1'b0, 2, 0, 0, "not_taken");
  endtask

  task automatic test_stall_wrap();
    do_branch(32'hFFFF_FFF8, 32'h10, 1'b1, 1'b1, 1, 2, 2, "stall_wrap");
    do_branch(32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 0, 1, 1, "to_top");
    run_cycles(3, 1'b0);
  endtask

  task automatic test_self_loop();
    do_branch(32'h500, 32'hFFFF_FFF8, 1'b0, 1'b1, 0, 0, 0, "self_loop0");
    do_branch(32'h500, 32'hFFFF_FFF8, 1'b0, 1'b1, 1, 0, 0, "self_loop1");
  endtask

  task automatic test_reset_mid_branch();
    // Reset while resolving a BL: the link write must never appear.
    bif.dec_valid = 1'b1; bif.dec_ib = 1'b1; bif.dec_link = 1'b1;
    bif.dec_pc = 32'h400; bif.dec_bv = 32'h20;
    step();
    bif.dec_valid = 1'b0; bif.dec_ib = 1'b0;
    reset = 1'b1; bif.ex_valid = 1'b1; bif.ex_cond_pass = 1'b1;
    step();
    checks++;
    if (obs() !== {RPC, 4'b0000} || bif.lr_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_resolve: got %h lr_data=%h, want %h", obs(), bif.lr_data, {RPC, 4'b0000});
    end
    reset = 1'b0; bif.ex_valid = 1'b0;
    step();
    checks++;
    if (obs() !== {RPC, 4'b1000}) begin
      failures++;
      $display("FAIL rst_resolve_after: got %h, want %h", obs(), {RPC, 4'b1000});
    end
    exp_pc = RPC;
    run_cycles(2, 1'b0);
    // Reset during the flush bubble.
    bif.dec_valid = 1'b1; bif.dec_ib = 1'b1; bif.dec_link = 1'b1;
    bif.dec_pc = 32'h600; bif.dec_bv = 32'h100;
    step();
    bif.dec_valid = 1'b0; bif.dec_ib = 1'b0;
    bif.ex_valid = 1'b1; bif.ex_cond_pass = 1'b1;
    step();
    bif.ex_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (obs() !== {RPC, 4'b0000}) begin
      failures++;
      $display("FAIL rst_flush: got %h, want %h", obs(), {RPC, 4'b0000});
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs() !== {RPC, 4'b1000}) begin
      failures++;
      $display("FAIL rst_flush_after: got %h, want %h", obs(), {RPC, 4'b1000});
    end
    exp_pc = RPC;
  endtask

  task automatic test_random();
    word_t pc, bv, r;
    for (int n = 0; n < 30; n++) begin
      run_cycles($urandom_range(0, 3), 1'b1);
      r  = $urandom;
      pc = {r[31:2], 2'b00};
      r  = $urandom;
      bv = {{18{r[13]}}, r[13:2], 2'b00};
      do_branch(pc, bv, 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_taken_b();
    test_taken_bl();
    test_not_taken();
    test_stall_wrap();
    test_self_loop();
    test_reset_mid_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
